// File: rtl/uart_alu_seq.sv
// Frame sequencer between a UART receiver and an ALU: collects opcode/A/B bytes,
// launches the ALU, and holds the captured result until the consumer acknowledges it.
module uart_alu_seq #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         TIMEOUT_CLKS = 20 * CLKS_PER_BIT,
    parameter logic [3:0] SYNC_NIB     = 4'hA
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic [3:0] o_alu_op,
    output logic [7:0] o_alu_a,
    output logic [7:0] o_alu_b,
    output logic       o_alu_start,
    input  logic [7:0] i_alu_result,
    input  logic [3:0] i_alu_flags,
    input  logic       i_alu_done,
    output logic [7:0] o_res_data,
    output logic [3:0] o_res_flags,
    output logic       o_res_valid,
    input  logic       i_res_ack,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        W_OP,
        W_A,
        W_B,
        EXEC,
        W_DONE,
        HOLD
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CLKS - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_cnt;
    logic [3:0]  r_alu_op;
    logic [7:0]  r_alu_a;
    logic [7:0]  r_alu_b;
    logic [7:0]  r_res_data;
    logic [3:0]  r_res_flags;
    logic        r_res_valid;
    logic        r_frame_err;
    logic        r_overrun;

    logic        w_accept;
    logic        w_frame_err;
    logic        w_overrun;
    logic        w_timeout;
    logic        w_capture;
    logic        w_release;

    assign w_timeout = (r_cnt == TO_LAST);
    assign w_capture = (r_state == W_DONE) && i_alu_done;
    assign w_release = (r_state == HOLD) && i_res_ack;

    // A byte arriving in the timeout cycle wins over the timeout.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_frame_err  = 1'b0;
        w_overrun    = 1'b0;
        case (r_state)
            W_OP: begin
                if (i_rx_valid) begin
                    if (i_rx_data[7:4] == SYNC_NIB) begin
                        w_accept     = 1'b1;
                        w_next_state = W_A;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end
            end
            W_A: begin
                if (i_rx_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = W_B;
                end else if (w_timeout) begin
                    w_frame_err  = 1'b1;
                    w_next_state = W_OP;
                end
            end
            W_B: begin
                if (i_rx_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = EXEC;
                end else if (w_timeout) begin
                    w_frame_err  = 1'b1;
                    w_next_state = W_OP;
                end
            end
            EXEC: begin
                w_overrun    = i_rx_valid;
                w_next_state = W_DONE;
            end
            W_DONE: begin
                w_overrun = i_rx_valid;
                if (i_alu_done) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                w_overrun = i_rx_valid;
                if (i_res_ack) begin
                    w_next_state = W_OP;
                end
            end
            default: begin
                w_next_state = W_OP;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= W_OP;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Inter-byte idle counter; only meaningful while waiting for operand bytes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if ((r_state == W_A) || (r_state == W_B)) begin
            r_cnt <= r_cnt + 16'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_alu_op <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
        end else if (w_accept) begin
            case (r_state)
                W_OP:    r_alu_op <= i_rx_data[3:0];
                W_A:     r_alu_a  <= i_rx_data;
                W_B:     r_alu_b  <= i_rx_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res_data  <= '0;
            r_res_flags <= '0;
            r_res_valid <= 1'b0;
        end else if (w_capture) begin
            r_res_data  <= i_alu_result;
            r_res_flags <= i_alu_flags;
            r_res_valid <= 1'b1;
        end else if (w_release) begin
            r_res_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= w_overrun;
        end
    end

    assign o_alu_op    = r_alu_op;
    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_start = (r_state == EXEC);
    assign o_res_data  = r_res_data;
    assign o_res_flags = r_res_flags;
    assign o_res_valid = r_res_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = (r_state != W_OP);

endmodule

// File: tb/tb_uart_alu_seq.sv
// Directed and randomized bench for uart_alu_seq; expected values come from a
// frame-level model of the opcode/operand/result rules kept in the bench.
module tb_uart_alu_seq;

    localparam int         CPB  = 4;
    localparam int         TO   = 20 * CPB;
    localparam logic [3:0] SYNC = 4'hA;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rxData;
    logic       rxValid;
    logic [3:0] aluOp;
    logic [7:0] aluA;
    logic [7:0] aluB;
    logic       aluStart;
    logic [7:0] aluResult;
    logic [3:0] aluFlags;
    logic       aluDone;
    logic [7:0] resData;
    logic [3:0] resFlags;
    logic       resValid;
    logic       resAck;
    logic       frameErr;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] expOp;
    logic [7:0] expA;
    logic [7:0] expB;
    logic [7:0] expResData;
    logic [3:0] expResFlags;
    logic       expResValid;

    always #5 clk = ~clk;

    uart_alu_seq #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TO),
        .SYNC_NIB(SYNC)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_rx_data(rxData),
        .i_rx_valid(rxValid),
        .o_alu_op(aluOp),
        .o_alu_a(aluA),
        .o_alu_b(aluB),
        .o_alu_start(aluStart),
        .i_alu_result(aluResult),
        .i_alu_flags(aluFlags),
        .i_alu_done(aluDone),
        .o_res_data(resData),
        .o_res_flags(resFlags),
        .o_res_valid(resValid),
        .i_res_ack(resAck),
        .o_frame_err(frameErr),
        .o_overrun(overrun),
        .o_busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rxData  = b;
        rxValid = 1'b1;
        tick();
        rxValid = 1'b0;
        rxData  = 8'($urandom);
    endtask

    task automatic modelReset();
        expOp       = '0;
        expA        = '0;
        expB        = '0;
        expResData  = '0;
        expResFlags = '0;
        expResValid = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "/op"},       aluOp,    0);
        checkOutput({tag, "/a"},        aluA,     0);
        checkOutput({tag, "/b"},        aluB,     0);
        checkOutput({tag, "/start"},    aluStart, 0);
        checkOutput({tag, "/resData"},  resData,  0);
        checkOutput({tag, "/resFlags"}, resFlags, 0);
        checkOutput({tag, "/resValid"}, resValid, 0);
        checkOutput({tag, "/frameErr"}, frameErr, 0);
        checkOutput({tag, "/overrun"},  overrun,  0);
        checkOutput({tag, "/busy"},     busy,     0);
    endtask

    task automatic checkHeld(input string tag);
        checkOutput({tag, "/op"},       aluOp,    expOp);
        checkOutput({tag, "/a"},        aluA,     expA);
        checkOutput({tag, "/b"},        aluB,     expB);
        checkOutput({tag, "/resData"},  resData,  expResData);
        checkOutput({tag, "/resFlags"}, resFlags, expResFlags);
        checkOutput({tag, "/resValid"}, resValid, expResValid);
    endtask

    // Sends a well-formed frame with idle gaps (each below the timeout) and leaves the DUT in W_DONE.
    task automatic sendFrame(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input int gapA, input int gapB);
        applyStimulus({SYNC, op});
        checkOutput("frame/busyAfterOp", busy, 1);
        checkOutput("frame/errAfterOp", frameErr, 0);
        idle(gapA);
        checkOutput("frame/busyBeforeA", busy, 1);
        applyStimulus(a);
        checkOutput("frame/noStartAfterA", aluStart, 0);
        checkOutput("frame/errAfterA", frameErr, 0);
        idle(gapB);
        checkOutput("frame/busyBeforeB", busy, 1);
        applyStimulus(b);
        expOp = op;
        expA  = a;
        expB  = b;
        checkOutput("frame/start", aluStart, 1);
        checkOutput("frame/errAfterB", frameErr, 0);
        checkHeld("frame/exec");
        tick();
        checkOutput("frame/startPulse", aluStart, 0);
        checkOutput("frame/busyDone", busy, 1);
    endtask

    task automatic finishAlu(input logic [7:0] result, input logic [3:0] flags, input int waitCycles);
        repeat (waitCycles) begin
            aluResult = 8'($urandom);
            aluFlags  = 4'($urandom);
            tick();
        end
        checkOutput("alu/noResultYet", resValid, expResValid);
        checkOutput("alu/busyWaiting", busy, 1);
        aluResult = result;
        aluFlags  = flags;
        aluDone   = 1'b1;
        tick();
        aluDone     = 1'b0;
        aluResult   = ~result;
        aluFlags    = ~flags;
        expResData  = result;
        expResFlags = flags;
        expResValid = 1'b1;
        checkHeld("alu/captured");
        checkOutput("alu/busyHold", busy, 1);
    endtask

    task automatic ackResult();
        resAck = 1'b1;
        tick();
        resAck      = 1'b0;
        expResValid = 1'b0;
        checkHeld("ack/released");
        checkOutput("ack/busy", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] nib;

        rst       = 1'b1;
        rxData    = 8'hA5;
        rxValid   = 1'b1;
        aluResult = 8'h5A;
        aluFlags  = 4'hF;
        aluDone   = 1'b1;
        resAck    = 1'b1;
        modelReset();
        tick();
        tick();
        checkReset("reset");
        rxValid = 1'b0;
        aluDone = 1'b0;
        resAck  = 1'b0;
        rst     = 1'b0;
        tick();
        checkReset("postReset");

        // Reference frame 0xA3, 0x25, 0x11 with result 0x36.
        sendFrame(4'h3, 8'h25, 8'h11, 0, 0);
        finishAlu(8'h36, 4'h0, 2);
        ackResult();

        // Bad sync nibble in W_OP.
        applyStimulus(8'h53);
        checkOutput("badSync/frameErr", frameErr, 1);
        checkOutput("badSync/busy", busy, 0);
        checkOutput("badSync/start", aluStart, 0);
        tick();
        checkOutput("badSync/pulseEnds", frameErr, 0);
        checkOutput("badSync/stillIdle", busy, 0);

        // Timeout while waiting for B, then a normal frame.
        applyStimulus(8'hA1);
        applyStimulus(8'h10);
        expOp = 4'h1;
        expA  = 8'h10;
        idle(TO - 1);
        checkOutput("toB/notYetErr", frameErr, 0);
        checkOutput("toB/notYetIdle", busy, 1);
        tick();
        checkOutput("toB/frameErr", frameErr, 1);
        checkOutput("toB/idle", busy, 0);
        tick();
        checkOutput("toB/pulseEnds", frameErr, 0);
        checkOutput("toB/noStart", aluStart, 0);
        sendFrame(4'($urandom), 8'($urandom), 8'($urandom), 1, 2);
        finishAlu(8'($urandom), 4'($urandom), 1);
        ackResult();

        // Timeout while waiting for A.
        applyStimulus({SYNC, 4'h7});
        expOp = 4'h7;
        idle(TO - 1);
        checkOutput("toA/notYetIdle", busy, 1);
        tick();
        checkOutput("toA/frameErr", frameErr, 1);
        checkOutput("toA/idle", busy, 0);
        checkHeld("toA/held");

        // A and B each on the exact timeout cycle; no timeout in W_DONE.
        sendFrame(4'($urandom), 8'($urandom), 8'($urandom), TO - 1, TO - 1);
        finishAlu(8'($urandom), 4'($urandom), TO + 5);
        checkOutput("edge/noFrameErr", frameErr, 0);
        ackResult();

        // Overrun in EXEC: a byte right behind B is dropped.
        applyStimulus({SYNC, 4'h9});
        applyStimulus(8'h44);
        rxData  = 8'h55;
        rxValid = 1'b1;
        tick();
        expOp = 4'h9;
        expA  = 8'h44;
        expB  = 8'h55;
        checkOutput("execOvr/start", aluStart, 1);
        rxData = 8'hA8;
        tick();
        rxValid = 1'b0;
        checkOutput("execOvr/overrun", overrun, 1);
        checkHeld("execOvr/held");

        // Overrun and ignored ack while in W_DONE.
        applyStimulus(8'hA2);
        checkOutput("doneOvr/overrun", overrun, 1);
        checkOutput("doneOvr/busy", busy, 1);
        resAck = 1'b1;
        tick();
        resAck = 1'b0;
        checkOutput("doneOvr/pulseEnds", overrun, 0);
        checkOutput("doneAck/ignored", busy, 1);
        finishAlu(8'hC3, 4'h9, 0);

        // Overrun in HOLD, then a byte coinciding with res_ack.
        applyStimulus(8'hA4);
        checkOutput("holdOvr/overrun", overrun, 1);
        checkHeld("holdOvr/held");
        rxData  = 8'hA6;
        rxValid = 1'b1;
        resAck  = 1'b1;
        tick();
        rxValid     = 1'b0;
        resAck      = 1'b0;
        expResValid = 1'b0;
        checkOutput("ackOvr/overrun", overrun, 1);
        checkOutput("ackOvr/busy", busy, 0);
        checkHeld("ackOvr/held");
        tick();
        checkOutput("ackOvr/notOpcode", busy, 0);
        checkOutput("ackOvr/pulseEnds", overrun, 0);

        // alu_done and res_ack outside their states are ignored.
        aluResult = 8'h11;
        aluFlags  = 4'h2;
        aluDone   = 1'b1;
        resAck    = 1'b1;
        tick();
        aluDone = 1'b0;
        resAck  = 1'b0;
        checkHeld("strayDone/held");
        checkOutput("strayDone/busy", busy, 0);

        // Reset in W_B.
        applyStimulus({SYNC, 4'h5});
        applyStimulus(8'h66);
        rst     = 1'b1;
        rxData  = 8'h77;
        rxValid = 1'b1;
        tick();
        rst     = 1'b0;
        rxValid = 1'b0;
        modelReset();
        checkReset("rstWB");
        tick();
        checkReset("rstWB/stays");

        // Reset in HOLD, with competing inputs.
        sendFrame(4'hE, 8'h81, 8'h7F, 0, 0);
        finishAlu(8'h00, 4'h4, 1);
        rst     = 1'b1;
        rxData  = {SYNC, 4'h1};
        rxValid = 1'b1;
        resAck  = 1'b1;
        tick();
        rst     = 1'b0;
        rxValid = 1'b0;
        resAck  = 1'b0;
        modelReset();
        checkReset("rstHold");

        // Randomized frames, some preceded by a bad sync byte.
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                nib = 4'($urandom);
                if (nib == SYNC) nib = nib ^ 4'h1;
                applyStimulus({nib, 4'($urandom)});
                checkOutput("rand/badSync", frameErr, 1);
                checkOutput("rand/badSyncIdle", busy, 0);
            end
            op = 4'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            sendFrame(op, a, b, $urandom_range(0, 5), $urandom_range(0, TO - 1));
            finishAlu(a + b, 4'($urandom), $urandom_range(0, 4));
            if ($urandom_range(0, 1) == 1) begin
                idle($urandom_range(1, 3));
                checkOutput("rand/holdStays", resValid, 1);
            end
            ackResult();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
